// File: rtl/freelist_alloc_arb_if.sv
// rtl/freelist_alloc_arb_if.sv - requester and free-list handshake bundle for freelist_alloc_arb
interface freelist_alloc_arb_if #(
  parameter int REQ   = 4,
  parameter int DATA  = 4,
  parameter int READ  = 4,
  parameter int WRITE = 4
);
  logic [REQ-1:0]        req;
  logic [REQ-1:0]        gnt;
  logic [REQ*DATA-1:0]   tag;
  logic [REQ-1:0]        tag_v;
  logic [REQ-1:0]        rel;
  logic [REQ*DATA-1:0]   rel_tag;
  logic                  rel_rdy;
  logic                  flush_req;
  logic                  busy;
  logic [READ-1:0]       fl_re_;
  logic [READ*DATA-1:0]  fl_rd;
  logic [READ-1:0]       fl_v;
  logic [WRITE-1:0]      fl_we_;
  logic [WRITE*DATA-1:0] fl_wd;
  logic                  fl_flush_;
  logic                  fl_busy;

  modport slave (
    input  req, rel, rel_tag, flush_req, fl_rd, fl_v, fl_busy,
    output gnt, tag, tag_v, rel_rdy, busy, fl_re_, fl_we_, fl_wd, fl_flush_
  );

  modport master (
    output req, rel, rel_tag, flush_req, fl_rd, fl_v, fl_busy,
    input  gnt, tag, tag_v, rel_rdy, busy, fl_re_, fl_we_, fl_wd, fl_flush_
  );
endinterface

// File: rtl/freelist_alloc_arb.sv
// rtl/freelist_alloc_arb.sv - free-list allocation arbiter, release coalescer and flush sequencer (round-robin via FL_ARB_RR_EN)
module freelist_alloc_arb #(
  parameter int REQ       = 4,
  parameter int DEPTH     = 16,
  parameter int DATA      = $clog2(DEPTH),
  parameter int READ      = 4,
  parameter int WRITE     = 4,
  parameter int REL_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  freelist_alloc_arb_if.slave  bus
);
  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int RW = (READ > 1) ? $clog2(READ) : 1;
  localparam int BW = (REL_DEPTH > 1) ? $clog2(REL_DEPTH) : 1;
  localparam int CW = $clog2(REL_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT} state_t;

  state_t              state_q;
  logic                wait_first_q;
  logic                busy_q;
  logic                flush_n_q;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic [REQ*DATA-1:0] tag_q, tag_d;
  logic [REQ-1:0]      tag_v_q;
  logic [REQ-1:0]      gnt_c;
  logic [READ-1:0]     re_n_c;
  logic [RW-1:0]       port_sel [REQ];
  logic [DATA-1:0]     rd_a [READ];
  logic                stop, grant_en;
  int                  n_avail, k, idx;

  logic [DATA-1:0]     mem_q [REL_DEPTH];
  logic [BW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       slot_c [REQ];
  logic [REQ-1:0]      enq_c;
  logic                rel_rdy_c;
  logic [WRITE-1:0]    we_n_c;
  logic [WRITE*DATA-1:0] wd_c;
  int                  n_enq, n_drain, pos;

  // Grant: scan requesters from the pointer; the k-th winner takes read port k,
  // limited to the run of available ports starting at port 0.
  always_comb begin
    n_avail = 0;
    stop    = 1'b0;
    for (int p = 0; p < READ; p++) begin
      rd_a[p] = bus.fl_rd[p*DATA +: DATA];
      if (!stop && bus.fl_v[p]) n_avail = n_avail + 1;
      else                      stop    = 1'b1;
    end
    for (int i = 0; i < REQ; i++) port_sel[i] = '0;
    grant_en = (state_q == S_IDLE) && !bus.fl_busy;
    k        = 0;
    gnt_c    = '0;
    re_n_c   = '1;
    ptr_d    = ptr_q;
    for (int j = 0; j < REQ; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= REQ) idx = idx - REQ;
      if (grant_en && bus.req[PW'(idx)] && (k < n_avail)) begin
        gnt_c[PW'(idx)]    = 1'b1;
        re_n_c[RW'(k)]     = 1'b0;
        port_sel[PW'(idx)] = RW'(k);
`ifdef FL_ARB_RR_EN
        ptr_d = (idx == REQ - 1) ? '0 : PW'(idx + 1);
`else
        ptr_d = '0;
`endif
        k = k + 1;
      end
    end
  end

  // Capture the read data of each granted requester's port into its tag slot
  always_comb begin
    tag_d = tag_q;
    for (int i = 0; i < REQ; i++) begin
      if (gnt_c[i]) tag_d[i*DATA +: DATA] = rd_a[port_sel[i]];
    end
  end

  // Release FIFO: enqueue set rel bits in requester order, drain oldest entries to write ports
  always_comb begin
    rel_rdy_c = (state_q == S_IDLE) && ((REL_DEPTH - int'(cnt_q)) >= REQ);
    n_enq     = 0;
    enq_c     = '0;
    for (int i = 0; i < REQ; i++) begin
      pos = int'(wr_q) + n_enq;
      if (pos >= REL_DEPTH) pos = pos - REL_DEPTH;
      slot_c[i] = BW'(pos);
      if (rel_rdy_c && bus.rel[i]) begin
        enq_c[i] = 1'b1;
        n_enq    = n_enq + 1;
      end
    end
    n_drain = 0;
    we_n_c  = '1;
    wd_c    = '0;
    for (int w = 0; w < WRITE; w++) begin
      pos = int'(rd_q) + w;
      if (pos >= REL_DEPTH) pos = pos - REL_DEPTH;
      if ((state_q == S_IDLE) && (w < int'(cnt_q))) begin
        we_n_c[w]            = 1'b0;
        wd_c[w*DATA +: DATA] = mem_q[BW'(pos)];
        n_drain              = n_drain + 1;
      end
    end
    rd_d  = BW'((int'(rd_q) + n_drain) % REL_DEPTH);
    wr_d  = BW'((int'(wr_q) + n_enq) % REL_DEPTH);
    cnt_d = CW'(int'(cnt_q) + n_enq - n_drain);
  end

  // Flush sequencer: IDLE -> FLUSH (one cycle) -> WAIT (two cycles minimum, then until list idle)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_first_q <= 1'b0;
      busy_q       <= 1'b0;
      flush_n_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.flush_req) begin
            state_q   <= S_FLUSH;
            busy_q    <= 1'b1;
            flush_n_q <= 1'b0;
          end
        end
        S_FLUSH: begin
          state_q      <= S_WAIT;
          wait_first_q <= 1'b1;
          flush_n_q    <= 1'b1;
        end
        S_WAIT: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && !bus.fl_busy) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          flush_n_q <= 1'b1;
        end
      endcase
    end
  end

  // Arbitration pointer and registered tag delivery
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      tag_q   <= '0;
      tag_v_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      tag_v_q <= gnt_c;
    end
  end

  // Release FIFO pointers; the flush cycle discards everything buffered
  always_ff @(posedge clk) begin
    if (reset || (state_q == S_FLUSH)) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Release FIFO storage; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ; i++) begin
      if (enq_c[i]) mem_q[slot_c[i]] <= bus.rel_tag[i*DATA +: DATA];
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.tag       = tag_q;
  assign bus.tag_v     = tag_v_q;
  assign bus.rel_rdy   = rel_rdy_c;
  assign bus.busy      = busy_q;
  assign bus.fl_re_    = re_n_c;
  assign bus.fl_we_    = we_n_c;
  assign bus.fl_wd     = wd_c;
  assign bus.fl_flush_ = flush_n_q;
endmodule
